// File: rtl/data_mem_responder_pkg.sv
// Shared types and widths for the MEM-stage data responder and its storage.
package data_mem_responder_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data-port bundle between the MEM stage (master) and the memory responder (slave).
interface data_mem_responder_if;
   import data_mem_responder_pkg::*;

   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic [DATA_W-1:0] rdata;
   logic              err;
   logic              stall;

   modport master (output req, we, addr, wdata, input ack, rdata, err, stall);
   modport slave  (input req, we, addr, wdata, output ack, rdata, err, stall);

endinterface

// File: rtl/data_mem_responder_dmem_array.sv
// Word storage: synchronous write, registered read, contents deliberately left unreset.
module data_mem_responder_dmem_array
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem [DEPTH_WORDS];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[idx_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem[idx_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Slow data-memory model: one access per request, fixed BUSY latency, one-cycle ack.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   data_mem_responder_if.slave  bus
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;
   logic              rdata_zero_q, rdata_zero_d;

   logic              access_go;
   logic              addr_err;
   logic              mem_we;
   logic              mem_re;
   logic [IDX_W-1:0]  mem_idx;
   logic [DATA_W-1:0] mem_rdata;

   // Checks use the captured address so mid-access bus changes cannot leak in.
   assign addr_err  = (addr_q[1:0] != 2'b00) || (addr_q[ADDR_W-1:IDX_W+2] != '0);
   assign mem_idx   = addr_q[IDX_W+1:2];
   assign access_go = (state_q == ST_BUSY) && (cnt_q == '0);
   assign mem_we    = access_go && we_q && !addr_err;
   assign mem_re    = access_go && !we_q && !addr_err;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      ack_d        = 1'b0;
      err_d        = 1'b0;
      rdata_zero_d = rdata_zero_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req) begin
               we_d    = bus.we;
               addr_d  = bus.addr;
               wdata_d = bus.wdata;
               cnt_d   = CNT_W'(LATENCY - 1);
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = ST_RESP;
               ack_d   = 1'b1;
               err_d   = addr_err;
               // Writes leave the last load value visible on rdata.
               if (addr_err) begin
                  rdata_zero_d = 1'b1;
               end else if (!we_q) begin
                  rdata_zero_d = 1'b0;
               end
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         ack_q        <= 1'b0;
         err_q        <= 1'b0;
         rdata_zero_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         ack_q        <= ack_d;
         err_q        <= err_d;
         rdata_zero_q <= rdata_zero_d;
      end
   end

   data_mem_responder_dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk_i   (clk_i),
      .we_i    (mem_we),
      .re_i    (mem_re),
      .idx_i   (mem_idx),
      .wdata_i (wdata_q),
      .rdata_o (mem_rdata)
   );

   // The array output is unreset, so a flag masks it after reset and on errors.
   assign bus.rdata = rdata_zero_q ? '0 : mem_rdata;
   assign bus.ack   = ack_q;
   assign bus.err   = err_q;
   assign bus.stall = ((state_q == ST_IDLE) && bus.req) || (state_q == ST_BUSY);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: LATENCY=4 and LATENCY=1 instances, cycle model plus literal checks.
module tb_data_mem_responder;

   localparam int DEPTH = 256;

   logic        clk;
   int          cyc;
   logic        rst_n_tb [2];
   logic        req_tb   [2];
   logic        we_tb    [2];
   logic [31:0] addr_tb  [2];
   logic [31:0] wdata_tb [2];
   logic        ack_tb   [2];
   logic [31:0] rdata_tb [2];
   logic        err_tb   [2];
   logic        stall_tb [2];

   int tests_run;
   int tests_failed;

   // Model state: acceptance cycle of the in-flight access, captured request, last load value.
   int          acc_c    [2];
   bit          m_we     [2];
   logic [31:0] m_addr   [2];
   logic [31:0] m_wdata  [2];
   logic [31:0] m_rdata  [2];
   bit          m_rknown [2];
   logic [31:0] mem_m [int];

   data_mem_responder_if ifc4 ();
   data_mem_responder_if ifc1 ();

   assign ifc4.req   = req_tb[0];
   assign ifc4.we    = we_tb[0];
   assign ifc4.addr  = addr_tb[0];
   assign ifc4.wdata = wdata_tb[0];
   assign ack_tb[0]   = ifc4.ack;
   assign rdata_tb[0] = ifc4.rdata;
   assign err_tb[0]   = ifc4.err;
   assign stall_tb[0] = ifc4.stall;

   assign ifc1.req   = req_tb[1];
   assign ifc1.we    = we_tb[1];
   assign ifc1.addr  = addr_tb[1];
   assign ifc1.wdata = wdata_tb[1];
   assign ack_tb[1]   = ifc1.ack;
   assign rdata_tb[1] = ifc1.rdata;
   assign err_tb[1]   = ifc1.err;
   assign stall_tb[1] = ifc1.stall;

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) u_dut4 (
      .clk_i (clk),
      .rst_i (rst_n_tb[0]),
      .bus   (ifc4.slave)
   );

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
      .clk_i (clk),
      .rst_i (rst_n_tb[1]),
      .bus   (ifc1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int lat_of(input int i);
      return (i == 0) ? 4 : 1;
   endfunction

   task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s dut%0d cyc=%0d: got 0x%08h, expected 0x%08h", name, i, cyc, act, exp);
      end
   endtask

   // Outputs follow from the acceptance cycle: stall for cycles 0..L, ack in cycle L+1.
   task automatic compare_loop();
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            bit e_ack, e_err, e_stall;
            int k;
            int key;
            e_ack = 1'b0;
            e_err = 1'b0;
            e_stall = 1'b0;
            if (!rst_n_tb[i]) begin
               acc_c[i]    = -1;
               m_rdata[i]  = 32'h0;
               m_rknown[i] = 1'b1;
               e_stall     = req_tb[i];
            end else if (acc_c[i] >= 0) begin
               k = cyc - acc_c[i];
               if (k <= lat_of(i)) begin
                  e_stall = 1'b1;
               end else begin
                  e_ack = 1'b1;
                  e_err = (m_addr[i] % 4 != 0) || (m_addr[i] >= 32'(4 * DEPTH));
                  key   = i * 4096 + int'(m_addr[i] / 4);
                  if (e_err) begin
                     m_rdata[i]  = 32'h0;
                     m_rknown[i] = 1'b1;
                  end else if (m_we[i]) begin
                     mem_m[key] = m_wdata[i];
                  end else if (mem_m.exists(key)) begin
                     m_rdata[i]  = mem_m[key];
                     m_rknown[i] = 1'b1;
                  end else begin
                     m_rknown[i] = 1'b0;
                  end
                  acc_c[i] = -1;
               end
            end else if (req_tb[i]) begin
               acc_c[i]   = cyc;
               m_we[i]    = we_tb[i];
               m_addr[i]  = addr_tb[i];
               m_wdata[i] = wdata_tb[i];
               e_stall    = 1'b1;
            end
            check("cmp_ack", i, 32'(ack_tb[i]), 32'(e_ack));
            check("cmp_err", i, 32'(err_tb[i]), 32'(e_err));
            check("cmp_stall", i, 32'(stall_tb[i]), 32'(e_stall));
            if (m_rknown[i]) begin
               check("cmp_rdata", i, rdata_tb[i], m_rdata[i]);
            end
         end
      end
   endtask

   task automatic access(input int i, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit wiggle, output logic [31:0] rd, output bit er, output int lat);
      int t0;
      bit got;
      @(posedge clk);
      #1;
      req_tb[i]   = 1'b1;
      we_tb[i]    = we;
      addr_tb[i]  = addr;
      wdata_tb[i] = wdata;
      t0  = cyc;
      got = 1'b0;
      lat = -1;
      rd  = 32'h0;
      er  = 1'b0;
      for (int n = 0; n < 40 && !got; n++) begin
         @(negedge clk);
         if (ack_tb[i]) begin
            got = 1'b1;
            lat = cyc - t0;
            rd  = rdata_tb[i];
            er  = err_tb[i];
         end else if (wiggle) begin
            @(posedge clk);
            #1;
            addr_tb[i]  = $urandom;
            wdata_tb[i] = $urandom;
         end
      end
      @(posedge clk);
      #1;
      req_tb[i] = 1'b0;
      if (!got) begin
         tests_run++;
         tests_failed++;
         $display("FAIL ack_timeout dut%0d addr=0x%08h: got no ack, expected ack within 40 cycles", i, addr);
      end
      $display("[TB] dut%0d %s addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d",
               i, we ? "WR" : "RD", addr, wdata, rd, er, lat);
   endtask

   initial begin
      logic [31:0] rd;
      bit          er;
      int          lat;
      logic        st [7];
      logic        ak [7];
      int          ack_at [$];

      tests_run = 0;
      tests_failed = 0;
      for (int i = 0; i < 2; i++) begin
         rst_n_tb[i] = 1'b0;
         req_tb[i]   = 1'b0;
         we_tb[i]    = 1'b0;
         addr_tb[i]  = 32'h0;
         wdata_tb[i] = 32'h0;
         acc_c[i]    = -1;
         m_rknown[i] = 1'b0;
         m_rdata[i]  = 32'h0;
      end
      fork
         compare_loop();
      join_none

      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check("rst_ack", i, 32'(ack_tb[i]), 32'h0);
         check("rst_err", i, 32'(err_tb[i]), 32'h0);
         check("rst_rdata", i, rdata_tb[i], 32'h0);
         check("rst_stall", i, 32'(stall_tb[i]), 32'h0);
      end
      @(posedge clk);
      #1;
      rst_n_tb[0] = 1'b1;
      rst_n_tb[1] = 1'b1;

      // T1: write then read, ack five cycles after request
      access(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, rd, er, lat);
      check("t1_wr_lat", 0, 32'(lat), 32'd5);
      check("t1_wr_err", 0, 32'(er), 32'h0);
      access(0, 1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat);
      check("t1_rd_lat", 0, 32'(lat), 32'd5);
      check("t1_rd_data", 0, rd, 32'hDEADBEEF);
      check("t1_rd_err", 0, 32'(er), 32'h0);

      // T2: misaligned and out-of-range accesses
      access(0, 1'b0, 32'h12, 32'h0, 1'b0, rd, er, lat);
      check("t2_mis_err", 0, 32'(er), 32'h1);
      check("t2_mis_data", 0, rd, 32'h0);
      access(0, 1'b0, 32'(4 * DEPTH), 32'h0, 1'b0, rd, er, lat);
      check("t2_oor_err", 0, 32'(er), 32'h1);
      check("t2_oor_data", 0, rd, 32'h0);
      access(0, 1'b1, 32'h410, 32'h0000BAD1, 1'b0, rd, er, lat);
      check("t2_oor_wr_err", 0, 32'(er), 32'h1);
      access(0, 1'b1, 32'h11, 32'h0000BAD2, 1'b0, rd, er, lat);
      check("t2_mis_wr_err", 0, 32'(er), 32'h1);
      access(0, 1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat);
      check("t2_unchanged", 0, rd, 32'hDEADBEEF);

      // T3: stall window and single-cycle ack
      @(posedge clk);
      #1;
      req_tb[0] = 1'b1;
      we_tb[0] = 1'b0;
      addr_tb[0] = 32'h10;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         st[c] = stall_tb[0];
         ak[c] = ack_tb[0];
      end
      @(posedge clk);
      #1;
      req_tb[0] = 1'b0;
      @(negedge clk);
      ak[6] = ack_tb[0];
      st[6] = stall_tb[0];
      for (int c = 0; c < 7; c++) begin
         check("t3_stall", 0, 32'(st[c]), (c <= 4) ? 32'h1 : 32'h0);
         check("t3_ack", 0, 32'(ak[c]), (c == 5) ? 32'h1 : 32'h0);
      end
      $display("[TB] dut0 RD addr=0x00000010 stall window checked over 7 cycles");

      // T4: reset mid-BUSY aborts the second write
      access(0, 1'b1, 32'h20, 32'h1, 1'b0, rd, er, lat);
      check("t4_wr1_err", 0, 32'(er), 32'h0);
      access(0, 1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat);
      check("t4_pre_rd", 0, rd, 32'hDEADBEEF);
      @(posedge clk);
      #1;
      req_tb[0] = 1'b1;
      we_tb[0] = 1'b1;
      addr_tb[0] = 32'h20;
      wdata_tb[0] = 32'h2;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
      rst_n_tb[0] = 1'b0;
      req_tb[0] = 1'b0;
      #1;
      check("t4_rst_ack", 0, 32'(ack_tb[0]), 32'h0);
      check("t4_rst_err", 0, 32'(err_tb[0]), 32'h0);
      check("t4_rst_rdata", 0, rdata_tb[0], 32'h0);
      check("t4_rst_stall", 0, 32'(stall_tb[0]), 32'h0);
      @(posedge clk);
      #1;
      rst_n_tb[0] = 1'b1;
      $display("[TB] dut0 WR addr=0x00000020 wdata=0x00000002 aborted by reset");
      access(0, 1'b0, 32'h20, 32'h0, 1'b0, rd, er, lat);
      check("t4_rd_after_rst", 0, rd, 32'h1);

      // T5: bus wiggles during BUSY are ignored
      access(0, 1'b1, 32'h30, 32'hA5A5A5A5, 1'b1, rd, er, lat);
      check("t5_wr_err", 0, 32'(er), 32'h0);
      check("t5_wr_lat", 0, 32'(lat), 32'd5);
      access(0, 1'b0, 32'h30, 32'h0, 1'b0, rd, er, lat);
      check("t5_rd_data", 0, rd, 32'hA5A5A5A5);

      // T6: LATENCY=1, req held across back-to-back reads
      access(1, 1'b1, 32'h40, 32'h11111111, 1'b0, rd, er, lat);
      check("t6_wr_lat", 1, 32'(lat), 32'd2);
      @(posedge clk);
      #1;
      req_tb[1] = 1'b1;
      we_tb[1] = 1'b0;
      addr_tb[1] = 32'h40;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         if (ack_tb[1]) begin
            ack_at.push_back(c);
            check("t6_rd_data", 1, rdata_tb[1], 32'h11111111);
         end
      end
      @(posedge clk);
      #1;
      req_tb[1] = 1'b0;
      check("t6_ack_count", 1, 32'(ack_at.size()), 32'd3);
      for (int j = 0; j < ack_at.size() && j < 3; j++) begin
         check("t6_ack_cycle", 1, 32'(ack_at[j]), 32'(2 + 3 * j));
      end
      $display("[TB] dut1 RD addr=0x00000040 back-to-back x%0d", ack_at.size());
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
